// File: rtl/sprite_engine.sv
// Sprite overlay stage: rectangle hit test against a movable origin, sprite-ROM addressing,
// latency-matched hit/background pipeline and keyed/blinking output select.
`timescale 1ns/1ps
module sprite_engine #(
  parameter int SPR_W = 224,
  parameter int SPR_H = 180,
  parameter int ADDR_W = 16,
  parameter int CW = 8,
  parameter int MEM_LAT = 1,
  parameter int INIT_X = 150,
  parameter int INIT_Y = 100,
  parameter logic [3*CW-1:0] KEY_RGB = 24'hFF00FF,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_load,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [CW-1:0]     mem_r,
  input  logic [CW-1:0]     mem_g,
  input  logic [CW-1:0]     mem_b,
  input  logic [CW-1:0]     bg_r,
  input  logic [CW-1:0]     bg_g,
  input  logic [CW-1:0]     bg_b,
  output logic [CW-1:0]     VGA_RED,
  output logic [CW-1:0]     VGA_GREEN,
  output logic [CW-1:0]     VGA_BLUE
);

  localparam int PIX_W = 3 * CW;
  localparam int BCW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int LIN_W = (ADDR_W > 22) ? ADDR_W : 22;

  logic [9:0]     ox_reg, oy_reg, pend_x_reg, pend_y_reg;
  logic           pend_valid_reg;
  logic [1:0]     active_mode_reg;
  logic [BCW-1:0] blink_cnt_reg;
  logic           blink_vis_reg;

  // Origin, mode and blink state only change at frame boundaries so a frame never tears.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ox_reg          <= 10'(INIT_X);
      oy_reg          <= 10'(INIT_Y);
      pend_x_reg      <= '0;
      pend_y_reg      <= '0;
      pend_valid_reg  <= 1'b0;
      active_mode_reg <= 2'b00;
      blink_cnt_reg   <= '0;
      blink_vis_reg   <= 1'b1;
    end else if (frame_start) begin
      active_mode_reg <= mode;
      pend_valid_reg  <= 1'b0;
      if (pos_load) begin
        ox_reg <= pos_x;
        oy_reg <= pos_y;
      end else if (pend_valid_reg) begin
        ox_reg <= pend_x_reg;
        oy_reg <= pend_y_reg;
      end
      if (blink_cnt_reg == BCW'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg <= '0;
        blink_vis_reg <= ~blink_vis_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end else if (pos_load) begin
      pend_x_reg     <= pos_x;
      pend_y_reg     <= pos_y;
      pend_valid_reg <= 1'b1;
    end
  end

  logic [10:0]      x_end, y_end, dx, dy;
  logic             hit;
  logic [LIN_W-1:0] lin;

  // 11-bit math keeps the right/bottom bound from wrapping, so off-screen parts simply clip.
  always_comb begin
    x_end    = {1'b0, ox_reg} + 11'(SPR_W);
    y_end    = {1'b0, oy_reg} + 11'(SPR_H);
    dx       = {1'b0, x} - {1'b0, ox_reg};
    dy       = {1'b0, y} - {1'b0, oy_reg};
    hit      = ({1'b0, x} >= {1'b0, ox_reg}) && ({1'b0, x} < x_end) &&
               ({1'b0, y} >= {1'b0, oy_reg}) && ({1'b0, y} < y_end);
    lin      = LIN_W'(dy) * LIN_W'(SPR_W) + LIN_W'(dx);
    mem_addr = hit ? lin[ADDR_W-1:0] : '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < MEM_LAT; gi++) begin : g_stage
      logic             hit_q, vis_q, hit_in, vis_in;
      logic [PIX_W-1:0] bg_q, bg_in;
      if (gi == 0) begin : g_src
        assign hit_in = hit;
        assign vis_in = blink_vis_reg;
        assign bg_in  = {bg_r, bg_g, bg_b};
      end else begin : g_src
        assign hit_in = g_stage[gi-1].hit_q;
        assign vis_in = g_stage[gi-1].vis_q;
        assign bg_in  = g_stage[gi-1].bg_q;
      end
      always_ff @(posedge CLK) begin
        if (RST) begin
          hit_q <= 1'b0;
          vis_q <= 1'b0;
          bg_q  <= '0;
        end else begin
          hit_q <= hit_in;
          vis_q <= vis_in;
          bg_q  <= bg_in;
        end
      end
    end
  endgenerate

  logic             hit_d, vis_d;
  logic [PIX_W-1:0] bg_d, mem_pix, pix_next, pix_reg;

  assign hit_d   = g_stage[MEM_LAT-1].hit_q;
  assign vis_d   = g_stage[MEM_LAT-1].vis_q;
  assign bg_d    = g_stage[MEM_LAT-1].bg_q;
  assign mem_pix = {mem_r, mem_g, mem_b};

  always_comb begin
    pix_next = mem_pix;
    if (active_mode_reg == 2'b00 || !hit_d) begin
      pix_next = bg_d;
    end else if (active_mode_reg == 2'b11 && !vis_d) begin
      pix_next = bg_d;
    end else if (active_mode_reg[1] && mem_pix == KEY_RGB) begin
      pix_next = bg_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) pix_reg <= '0;
    else     pix_reg <= pix_next;
  end

  assign VGA_RED   = pix_reg[3*CW-1:2*CW];
  assign VGA_GREEN = pix_reg[2*CW-1:CW];
  assign VGA_BLUE  = pix_reg[CW-1:0];

endmodule

// File: tb/tb_sprite_engine.sv
// Randomised bench for sprite_engine: queue-based reference model of the overlay path
// plus directed scenarios for addressing, clipping, origin update, keying, blink and reset.
`timescale 1ns/1ps
module tb_sprite_engine;

  localparam int SPR_W = 224;
  localparam int SPR_H = 180;
  localparam int ADDR_W = 16;
  localparam int CW = 8;
  localparam int MEM_LAT = 1;
  localparam int INIT_X = 150;
  localparam int INIT_Y = 100;
  localparam logic [23:0] KEY = 24'hFF00FF;
  localparam int BLINK_FRAMES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] x = '0, y = '0, pos_x = '0, pos_y = '0;
  logic frame_start = 1'b0, pos_load = 1'b0, key_force = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [23:0] bg = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [CW-1:0] mem_r, mem_g, mem_b, vga_r, vga_g, vga_b;

  sprite_engine #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .CW(CW), .MEM_LAT(MEM_LAT),
    .INIT_X(INIT_X), .INIT_Y(INIT_Y), .KEY_RGB(KEY), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .CLK(clk), .RST(rst), .x(x), .y(y), .frame_start(frame_start),
    .pos_x(pos_x), .pos_y(pos_y), .pos_load(pos_load), .mode(mode),
    .mem_addr(mem_addr), .mem_r(mem_r), .mem_g(mem_g), .mem_b(mem_b),
    .bg_r(bg[23:16]), .bg_g(bg[15:8]), .bg_b(bg[7:0]),
    .VGA_RED(vga_r), .VGA_GREEN(vga_g), .VGA_BLUE(vga_b)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] hash(input logic [15:0] a);
    return {a[7:0] ^ 8'h3C, a[15:8], a[7:0]};
  endfunction

  // Sprite memory: data is a fixed function of the address, or the key colour on demand.
  logic [23:0] mem_pipe [MEM_LAT];
  always @(posedge clk) begin
    mem_pipe[0] <= key_force ? KEY : hash(mem_addr);
    for (int i = 1; i < MEM_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign {mem_r, mem_g, mem_b} = mem_pipe[MEM_LAT-1];

  typedef struct packed {
    logic        hit;
    logic [23:0] bgv;
    logic        vis;
    logic [23:0] memv;
  } rec_t;

  rec_t q[$];
  int m_ox, m_oy, m_px, m_py, m_bcnt;
  bit m_pv, m_bvis;
  logic [1:0] m_mode;

  int checks = 0, failures = 0;
  logic [15:0] got_addr, exp_addr;
  logic [23:0] got_vga, exp_vga;

  // One clock of model + DUT; leaves got_/exp_ values for the caller to compare.
  task automatic cycle();
    rec_t r, o;
    int ax, ay;
    bit mh;
    @(negedge clk);
    ax = int'(x);
    ay = int'(y);
    mh = (ax >= m_ox) && (ax < m_ox + SPR_W) && (ay >= m_oy) && (ay < m_oy + SPR_H);
    exp_addr = mh ? 16'(((ay - m_oy) * SPR_W + (ax - m_ox)) % 65536) : 16'd0;
    got_addr = mem_addr;
    if (rst) begin
      exp_vga = '0;
    end else begin
      r.hit = mh; r.bgv = bg; r.vis = m_bvis;
      r.memv = key_force ? KEY : hash(exp_addr);
      q.push_back(r);
      o = q.pop_front();
      if (m_mode == 2'b00 || !o.hit)                exp_vga = o.bgv;
      else if (m_mode == 2'b11 && !o.vis)          exp_vga = o.bgv;
      else if (m_mode[1] && o.memv == KEY)         exp_vga = o.bgv;
      else                                         exp_vga = o.memv;
    end
    @(posedge clk);
    #1;
    got_vga = {vga_r, vga_g, vga_b};
    if (rst) begin
      m_ox = INIT_X; m_oy = INIT_Y; m_pv = 0; m_px = 0; m_py = 0;
      m_mode = 2'b00; m_bcnt = 0; m_bvis = 1;
      q.delete();
      for (int i = 0; i < MEM_LAT; i++) q.push_back('0);
    end else if (frame_start) begin
      m_mode = mode;
      if (pos_load) begin m_ox = int'(pos_x); m_oy = int'(pos_y); end
      else if (m_pv) begin m_ox = m_px; m_oy = m_py; end
      m_pv = 0;
      if (m_bcnt == BLINK_FRAMES - 1) begin m_bcnt = 0; m_bvis = !m_bvis; end
      else m_bcnt++;
    end else if (pos_load) begin
      m_px = int'(pos_x); m_py = int'(pos_y); m_pv = 1;
    end
  endtask

  task automatic set_pix(input int xx, input int yy);
    x = 10'(xx);
    y = 10'(yy);
  endtask

  task automatic flush();
    set_pix(0, 0);
    repeat (MEM_LAT) cycle();
  endtask

  task automatic test_reset();
    rst = 1; mode = 2'b01; bg = 24'h123456;
    cycle(); cycle();
    checks++; if (got_vga !== 24'h0) begin failures++; $display("FAIL reset_vga got=%h exp=000000", got_vga); end
    rst = 0; set_pix(150, 100);
    cycle();
    checks++; if (got_addr !== 16'd0) begin failures++; $display("FAIL reset_addr0 got=%0d exp=0", got_addr); end
    checks++; if (got_vga !== 24'h0) begin failures++; $display("FAIL reset_first_out got=%h exp=000000", got_vga); end
    set_pix(151, 100);
    cycle();
    checks++; if (got_addr !== 16'd1) begin failures++; $display("FAIL reset_addr1 got=%0d exp=1", got_addr); end
    checks++; if (got_vga !== 24'h123456) begin failures++; $display("FAIL reset_mode_off got=%h exp=123456", got_vga); end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_opaque();
    mode = 2'b01; frame_start = 1; set_pix(0, 0);
    cycle();
    frame_start = 0; bg = 24'h0F0F0F;
    set_pix(150, 100); cycle();
    checks++; if (got_addr !== 16'd0) begin failures++; $display("FAIL opaque_addr_origin got=%0d exp=0", got_addr); end
    flush();
    checks++; if (got_vga !== hash(16'd0)) begin failures++; $display("FAIL opaque_vga_origin got=%h exp=%h", got_vga, hash(16'd0)); end
    set_pix(151, 101); cycle();
    checks++; if (got_addr !== 16'd225) begin failures++; $display("FAIL opaque_addr_225 got=%0d exp=225", got_addr); end
    set_pix(149, 100); cycle();
    checks++; if (got_addr !== 16'd0) begin failures++; $display("FAIL opaque_left_miss got=%0d exp=0", got_addr); end
    set_pix(374, 100); cycle();
    checks++; if (got_addr !== 16'd0) begin failures++; $display("FAIL opaque_right_miss got=%0d exp=0", got_addr); end
    flush();
    checks++; if (got_vga !== 24'h0F0F0F) begin failures++; $display("FAIL opaque_right_bg got=%h exp=0f0f0f", got_vga); end
    $display("test_opaque done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_clip();
    frame_start = 1; pos_load = 1; pos_x = 10'd600; pos_y = 10'd400; set_pix(0, 0);
    cycle();
    frame_start = 0; pos_load = 0; bg = 24'h202020;
    set_pix(639, 479); cycle();
    checks++; if (got_addr !== 16'd17735) begin failures++; $display("FAIL clip_corner_addr got=%0d exp=17735", got_addr); end
    flush();
    checks++; if (got_vga !== hash(16'd17735)) begin failures++; $display("FAIL clip_corner_vga got=%h exp=%h", got_vga, hash(16'd17735)); end
    set_pix(599, 400); cycle();
    checks++; if (got_addr !== 16'd0) begin failures++; $display("FAIL clip_left_addr got=%0d exp=0", got_addr); end
    flush();
    checks++; if (got_vga !== 24'h202020) begin failures++; $display("FAIL clip_left_vga got=%h exp=202020", got_vga); end
    set_pix(20, 410); cycle();
    checks++; if (got_addr !== 16'd0) begin failures++; $display("FAIL clip_nowrap got=%0d exp=0", got_addr); end
    $display("test_clip done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_origin();
    pos_load = 1; pos_x = 10'd10; pos_y = 10'd20; set_pix(11, 21);
    cycle();
    pos_load = 0;
    checks++; if (got_addr !== 16'd0) begin failures++; $display("FAIL origin_load_cycle got=%0d exp=0", got_addr); end
    cycle();
    checks++; if (got_addr !== 16'd0) begin failures++; $display("FAIL origin_pending_held got=%0d exp=0", got_addr); end
    frame_start = 1; cycle(); frame_start = 0;
    cycle();
    checks++; if (got_addr !== 16'd225) begin failures++; $display("FAIL origin_applied got=%0d exp=225", got_addr); end
    frame_start = 1; pos_load = 1; pos_x = 10'd30; pos_y = 10'd40; cycle();
    frame_start = 0; pos_load = 0;
    set_pix(31, 41); cycle();
    checks++; if (got_addr !== 16'd225) begin failures++; $display("FAIL origin_direct got=%0d exp=225", got_addr); end
    frame_start = 1; cycle(); frame_start = 0;
    cycle();
    checks++; if (got_addr !== 16'd225) begin failures++; $display("FAIL origin_no_pending got=%0d exp=225", got_addr); end
    $display("test_origin done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_keyed();
    frame_start = 1; pos_load = 1; pos_x = 10'd200; pos_y = 10'd200; mode = 2'b10; set_pix(0, 0);
    cycle();
    frame_start = 0; pos_load = 0; bg = 24'h111111;
    key_force = 1; set_pix(205, 210); cycle();
    checks++; if (got_addr !== 16'd2245) begin failures++; $display("FAIL keyed_addr got=%0d exp=2245", got_addr); end
    key_force = 0; flush();
    checks++; if (got_vga !== 24'h111111) begin failures++; $display("FAIL keyed_transparent got=%h exp=111111", got_vga); end
    set_pix(205, 210); cycle();
    flush();
    checks++; if (got_vga !== hash(16'd2245)) begin failures++; $display("FAIL keyed_opaque got=%h exp=%h", got_vga, hash(16'd2245)); end
    $display("test_keyed done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_blink();
    bit vis_tab [6] = '{1, 0, 0, 1, 1, 0};
    logic [23:0] want;
    rst = 1; cycle(); rst = 0;
    mode = 2'b11; bg = 24'h0A0B0C; key_force = 0;
    for (int k = 0; k < 6; k++) begin
      frame_start = 1; set_pix(0, 0); cycle();
      frame_start = 0; set_pix(153, 100); cycle();
      flush();
      want = vis_tab[k] ? hash(16'd3) : 24'h0A0B0C;
      checks++;
      if (got_vga !== want) begin failures++; $display("FAIL blink_frame%0d got=%h exp=%h", k, got_vga, want); end
    end
    $display("test_blink done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid();
    mode = 2'b01; frame_start = 1; set_pix(0, 0); cycle(); frame_start = 0;
    pos_load = 1; pos_x = 10'd5; pos_y = 10'd5; cycle(); pos_load = 0;
    set_pix(151, 101); cycle();
    rst = 1; cycle();
    checks++; if (got_vga !== 24'h0) begin failures++; $display("FAIL midreset_vga got=%h exp=000000", got_vga); end
    rst = 0; bg = 24'h777777; set_pix(151, 101); cycle();
    checks++; if (got_addr !== 16'd225) begin failures++; $display("FAIL midreset_origin got=%0d exp=225", got_addr); end
    cycle();
    checks++; if (got_vga !== 24'h777777) begin failures++; $display("FAIL midreset_mode_off got=%h exp=777777", got_vga); end
    frame_start = 1; cycle(); frame_start = 0;
    cycle();
    checks++; if (got_addr !== 16'd225) begin failures++; $display("FAIL midreset_pending_dropped got=%0d exp=225", got_addr); end
    flush();
    checks++; if (got_vga !== hash(16'd225)) begin failures++; $display("FAIL midreset_mode_on got=%h exp=%h", got_vga, hash(16'd225)); end
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    int f0;
    f0 = failures;
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(0, 999) == 0);
      frame_start = ($urandom_range(0, 149) == 0);
      pos_load    = ($urandom_range(0, 99) == 0);
      pos_x       = 10'($urandom_range(0, 1023));
      pos_y       = 10'($urandom_range(0, 1023));
      mode        = 2'($urandom_range(0, 3));
      key_force   = ($urandom_range(0, 3) == 0);
      bg          = 24'($urandom);
      set_pix(m_ox + int'($urandom_range(0, SPR_W + 16)) - 8,
              m_oy + int'($urandom_range(0, SPR_H + 16)) - 8);
      cycle();
      checks++;
      if (got_addr !== exp_addr) begin
        failures++;
        if (failures - f0 < 10) $display("FAIL rand_addr n=%0d got=%0d exp=%0d", n, got_addr, exp_addr);
      end
      checks++;
      if (got_vga !== exp_vga) begin
        failures++;
        if (failures - f0 < 10) $display("FAIL rand_vga n=%0d got=%h exp=%h", n, got_vga, exp_vga);
      end
    end
    rst = 0; frame_start = 0; pos_load = 0; key_force = 0;
    $display("test_random done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_opaque();
    test_clip();
    test_origin();
    test_keyed();
    test_blink();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_engine.md
Name: sprite_engine

Overview:
Parametrised sprite overlay stage for the VGA pixel path. It generates the sprite-ROM read address from the current pixel coordinates and a runtime-movable origin, and pipelines the hit decision and background to match the external memory latency. It outputs either the sprite pixel or the background, with colour-key transparency and a frame-synchronous blink mode. It sits between the VGA timing generator and the DAC, with one instance per sprite layer.

Parameters:
SPR_W, 224, sprite width in pixels
SPR_H, 180, sprite height in pixels
ADDR_W, 16, sprite memory address width; SPR_W*SPR_H must be <= 2**ADDR_W
CW, 8, bits per colour channel
MEM_LAT, 1, read latency of the sprite memory in cycles (1..4)
INIT_X, 150, origin x after reset
INIT_Y, 100, origin y after reset
KEY_RGB, 24'hFF00FF, transparent colour key {R,G,B}; the lower 3*CW bits are used
BLINK_FRAMES, 30, frames per blink half-period (>=1)

Ports:
CLK  in  1  pixel clock
RST  in  1  synchronous active-high reset
x  in  10  current pixel column
y  in  10  current pixel row
frame_start  in  1  one-cycle pulse at the start of each frame
pos_x  in  10  requested origin x
pos_y  in  10  requested origin y
pos_load  in  1  pulse; captures pos_x/pos_y as pending origin
mode  in  2  00 off, 01 opaque, 10 keyed, 11 keyed+blink
mem_addr  out  ADDR_W  sprite memory read address (combinational from x, y, origin)
mem_r/mem_g/mem_b  in  CW each  sprite memory data, valid MEM_LAT cycles after mem_addr
bg_r/bg_g/bg_b  in  CW each  background pixel aligned with x/y
VGA_RED/VGA_GREEN/VGA_BLUE  out  CW each  registered output pixel

Behaviour:
- Single clock, CLK. RST is synchronous and active-high.
- Reset values:
  - VGA_* = 0.
  - origin = (INIT_X, INIT_Y); pending_valid = 0.
  - active_mode = 00.
  - blink_cnt = 0; blink_vis = 1.
  - Hit/background pipeline registers cleared.
  - RST asserted mid-frame takes effect on the next edge; the first output after deassertion is valid MEM_LAT+1 cycles later. Outputs are 0 until then.
- Origin update (tear-free):
  - pos_load stores pos_x/pos_y into the pending registers and sets pending_valid. A later pos_load before frame_start overwrites the pending value.
  - On frame_start with pending_valid: origin <= pending, pending_valid <= 0.
  - If pos_load and frame_start occur in the same cycle, the new pos values go directly to origin and pending_valid ends at 0.
- mode is sampled into active_mode only on frame_start, so the mode never changes mid-frame.
- Hit test:
  - Use 11-bit unsigned arithmetic: dx = x - ox, dy = y - oy.
  - hit = (x >= ox) && (x < ox + SPR_W) && (y >= oy) && (y < oy + SPR_H).
  - Left/top edges are inclusive; right/bottom edges are exclusive.
  - A sprite extending past the screen is clipped. There is no wrap-around.
- Address:
  - mem_addr = dy*SPR_W + dx, truncated to ADDR_W, when hit.
  - mem_addr = 0 when not hit.
- Pipeline:
  - hit, bg_* and a blink-visible flag are delayed by MEM_LAT stages to align with mem_*.
  - The output register adds one more stage. Total latency x/y -> VGA_* = MEM_LAT+1 cycles.
- Output select (evaluated at the aligned stage), first matching rule wins:
  1. active_mode=00, or !hit_d -> bg.
  2. active_mode=11 and !blink_vis_d -> bg.
  3. active_mode in {10,11} and {mem_r,mem_g,mem_b} == KEY_RGB -> bg.
  4. Otherwise -> mem.
- Blink:
  - On each frame_start: if blink_cnt == BLINK_FRAMES-1, then blink_cnt <= 0 and blink_vis toggles; else blink_cnt increments.
  - The counter runs in all modes.

Test Plan:
1. Reset, mode=01 latched at frame_start, origin (150,100), MEM_LAT=1, memory model returns the address as its data. Scan (150,100) -> mem_addr=0, VGA = mem data 2 cycles later. Scan (151,101) -> mem_addr=225. Scan (149,100) and (374,100) -> bg.
2. Edge/clip: origin (600,400), pixel (639,479) -> hit, mem_addr = 79*224+39 = 17735. Pixel (599,400) -> bg. Nothing wraps to x<600.
3. pos_load (10,20) mid-frame -> origin unchanged until the next frame_start, then (10,20). pos_load (30,40) together with frame_start -> origin (30,40) immediately and pending_valid = 0.
4. mode=10, mem returns FF00FF at a hit pixel -> VGA = bg. mem returns 123456 -> VGA = 123456.
5. mode=11, BLINK_FRAMES=2, four frame_starts -> sprite visible for frames 0-1, bg only for frames 2-3, visible again at frame 4.
6. RST pulse mid-scan with a pending origin (5,5) -> origin back to (150,100), pending discarded, VGA = 0 on the cycle after RST, mode off until the next frame_start.
